// File: rtl/ps2_key_decoder_pkg.sv
// ps2_key_decoder_pkg
//   Shared definitions for the PS/2 keyboard front end:
//   - PS/2 set-2 prefix/control scancodes
//   - game key codes (0 = no key)
//   - decoder state type and per-event flag struct
//   - scan_to_key(): scancode (+ extended context) -> key code
package ps2_key_decoder_pkg;

    // Prefix / control scancodes
    localparam logic [7:0] SC_F0 = 8'hF0;   // break prefix
    localparam logic [7:0] SC_E0 = 8'hE0;   // extended prefix
    localparam logic [7:0] SC_E1 = 8'hE1;   // pause-sequence prefix
    localparam logic [7:0] SC_AA = 8'hAA;   // self-test passed
    localparam logic [7:0] SC_FA = 8'hFA;   // acknowledge
    localparam logic [7:0] SC_EE = 8'hEE;   // echo
    localparam logic [7:0] SC_FE = 8'hFE;   // resend request

    // Width of the native key code space produced by scan_to_key()
    localparam int unsigned KEY_ID_W = 5;

    localparam logic [KEY_ID_W-1:0] KEY_NONE  = 5'd0;
    localparam logic [KEY_ID_W-1:0] KEY_Q     = 5'd1;
    localparam logic [KEY_ID_W-1:0] KEY_W     = 5'd2;
    localparam logic [KEY_ID_W-1:0] KEY_E     = 5'd3;
    localparam logic [KEY_ID_W-1:0] KEY_R     = 5'd4;
    localparam logic [KEY_ID_W-1:0] KEY_T     = 5'd5;
    localparam logic [KEY_ID_W-1:0] KEY_Y     = 5'd6;
    localparam logic [KEY_ID_W-1:0] KEY_U     = 5'd7;
    localparam logic [KEY_ID_W-1:0] KEY_I     = 5'd8;
    localparam logic [KEY_ID_W-1:0] KEY_O     = 5'd9;
    localparam logic [KEY_ID_W-1:0] KEY_P     = 5'd10;
    localparam logic [KEY_ID_W-1:0] KEY_A     = 5'd11;
    localparam logic [KEY_ID_W-1:0] KEY_S     = 5'd12;
    localparam logic [KEY_ID_W-1:0] KEY_D     = 5'd13;
    localparam logic [KEY_ID_W-1:0] KEY_F     = 5'd14;
    localparam logic [KEY_ID_W-1:0] KEY_G     = 5'd15;
    localparam logic [KEY_ID_W-1:0] KEY_H     = 5'd16;
    localparam logic [KEY_ID_W-1:0] KEY_J     = 5'd17;
    localparam logic [KEY_ID_W-1:0] KEY_K     = 5'd18;
    localparam logic [KEY_ID_W-1:0] KEY_L     = 5'd19;
    localparam logic [KEY_ID_W-1:0] KEY_Z     = 5'd20;
    localparam logic [KEY_ID_W-1:0] KEY_X     = 5'd21;
    localparam logic [KEY_ID_W-1:0] KEY_C     = 5'd22;
    localparam logic [KEY_ID_W-1:0] KEY_V     = 5'd23;
    localparam logic [KEY_ID_W-1:0] KEY_B     = 5'd24;
    localparam logic [KEY_ID_W-1:0] KEY_N     = 5'd25;
    localparam logic [KEY_ID_W-1:0] KEY_M     = 5'd26;
    localparam logic [KEY_ID_W-1:0] KEY_ENTER = 5'd27;
    localparam logic [KEY_ID_W-1:0] KEY_ESC   = 5'd28;
    localparam logic [KEY_ID_W-1:0] KEY_BKSP  = 5'd29;
    localparam logic [KEY_ID_W-1:0] KEY_LEFT  = 5'd30;
    localparam logic [KEY_ID_W-1:0] KEY_RIGHT = 5'd31;

    // Decoder prefix-tracking states
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } dec_state_t;

    // Per-event flags stored alongside the key code in the event FIFO
    typedef struct packed {
        logic brk;   // key up
        logic rpt;   // make for a key already held
    } evt_flags_t;

    localparam int unsigned EVT_FLAG_W = $bits(evt_flags_t);

    function automatic logic [KEY_ID_W-1:0] scan_to_key(input logic [7:0] sc,
                                                         input logic       ext);
        logic [KEY_ID_W-1:0] k;
        k = KEY_NONE;
        if (ext) begin
            case (sc)
                8'h6B:   k = KEY_LEFT;
                8'h74:   k = KEY_RIGHT;
                default: k = KEY_NONE;
            endcase
        end else begin
            case (sc)
                8'h15:   k = KEY_Q;
                8'h1D:   k = KEY_W;
                8'h24:   k = KEY_E;
                8'h2D:   k = KEY_R;
                8'h2C:   k = KEY_T;
                8'h35:   k = KEY_Y;
                8'h3C:   k = KEY_U;
                8'h43:   k = KEY_I;
                8'h44:   k = KEY_O;
                8'h4D:   k = KEY_P;
                8'h1C:   k = KEY_A;
                8'h1B:   k = KEY_S;
                8'h23:   k = KEY_D;
                8'h2B:   k = KEY_F;
                8'h34:   k = KEY_G;
                8'h33:   k = KEY_H;
                8'h3B:   k = KEY_J;
                8'h42:   k = KEY_K;
                8'h4B:   k = KEY_L;
                8'h1A:   k = KEY_Z;
                8'h22:   k = KEY_X;
                8'h21:   k = KEY_C;
                8'h2A:   k = KEY_V;
                8'h32:   k = KEY_B;
                8'h31:   k = KEY_N;
                8'h3A:   k = KEY_M;
                8'h5A:   k = KEY_ENTER;
                8'h76:   k = KEY_ESC;
                8'h66:   k = KEY_BKSP;
                default: k = KEY_NONE;
            endcase
        end
        return k;
    endfunction

endpackage

// File: rtl/ps2_key_decoder_frame_rx.sv
// ps2_key_decoder_frame_rx
//   PS/2 device-to-host frame receiver.
//   Ports:
//     clk, rst_n      system clock, synchronous active-low reset
//     PS2Clk, PS2Data raw asynchronous PS/2 lines
//     rx_byte         last correctly received data byte
//     byte_valid      one-cycle pulse: rx_byte holds a new byte
//     frame_err       one-cycle pulse: start/parity/stop error or mid-frame timeout
module ps2_key_decoder_frame_rx #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       PS2Clk,
    input  logic       PS2Data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic             clk_meta, clk_sync, clk_filt, clk_prev;
    logic             dat_meta, dat_sync, dat_filt;
    logic [FLT_W-1:0] clk_cnt, dat_cnt;
    logic [3:0]       bit_cnt;
    logic [9:0]       shreg;
    logic [TMR_W-1:0] timer;
    logic             fall;

    // Synchronisers and glitch filters. A filtered level flips only after
    // FILTER_LEN consecutive samples disagree with it; any agreeing sample
    // restarts the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            clk_filt <= 1'b1;
            clk_cnt  <= '0;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
            dat_filt <= 1'b1;
            dat_cnt  <= '0;
            clk_prev <= 1'b1;
        end else begin
            clk_meta <= PS2Clk;
            clk_sync <= clk_meta;
            dat_meta <= PS2Data;
            dat_sync <= dat_meta;
            clk_prev <= clk_filt;

            if (clk_sync == clk_filt) begin
                clk_cnt <= '0;
            end else if (clk_cnt == FLT_LAST) begin
                clk_filt <= clk_sync;
                clk_cnt  <= '0;
            end else begin
                clk_cnt <= clk_cnt + 1'b1;
            end

            if (dat_sync == dat_filt) begin
                dat_cnt <= '0;
            end else if (dat_cnt == FLT_LAST) begin
                dat_filt <= dat_sync;
                dat_cnt  <= '0;
            end else begin
                dat_cnt <= dat_cnt + 1'b1;
            end
        end
    end

    assign fall = clk_prev & ~clk_filt;

    // Bits enter at shreg[9] and move down, so after ten edges shreg[0] is
    // the start bit, shreg[8:1] the data and shreg[9] the parity bit; the
    // stop bit is checked straight off the line on the eleventh edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            timer      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall) begin
                timer <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= '0;
                    if (!shreg[0] && dat_filt && (^shreg[9:1])) begin
                        rx_byte    <= shreg[8:1];
                        byte_valid <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else begin
                    shreg   <= {dat_filt, shreg[9:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != 4'd0) begin
                if (timer == TMR_LAST) begin
                    bit_cnt   <= '0;
                    timer     <= '0;
                    frame_err <= 1'b1;
                end else begin
                    timer <= timer + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//   PS/2 keyboard front end: frame reception, E0/F0 prefix decoding,
//   scancode-to-key mapping, held-key bitmap and a ready/valid event FIFO.
//   Ports:
//     clk, rst_n      system clock, synchronous active-low reset
//     PS2Clk, PS2Data raw asynchronous PS/2 lines
//     evt_valid       FIFO head holds an event
//     evt_ready       consumer accepts the head event
//     evt_code        key code of head event
//     evt_release     head event is a key release
//     evt_repeat      head event is a make for a key already held
//     key_down        bit k set while key code k is held (bit 0 unused)
//     frame_err       one-cycle pulse on a bad or timed-out frame
//     overflow        one-cycle pulse when an event is dropped (FIFO full)
module ps2_key_decoder
    import ps2_key_decoder_pkg::*;
#(
    parameter int unsigned CODE_W         = 5,
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 PS2Clk,
    input  logic                 PS2Data,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [CODE_W-1:0]    evt_code,
    output logic                 evt_release,
    output logic                 evt_repeat,
    output logic [2**CODE_W-1:0] key_down,
    output logic                 frame_err,
    output logic                 overflow
);

    localparam int unsigned NUM_KEYS = 2**CODE_W;
    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;

    logic [7:0] rx_byte;
    logic       byte_valid;

    ps2_key_decoder_frame_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .PS2Clk    (PS2Clk),
        .PS2Data   (PS2Data),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .frame_err (frame_err)
    );

    // ---------------------------------------------------------------
    // Prefix decoder
    // ---------------------------------------------------------------
    dec_state_t          state;
    logic [KEY_ID_W-1:0] mapped;
    logic                code_ok;
    logic                is_ignored;
    logic                emit_vld;
    logic                emit_brk;
    logic [CODE_W-1:0]   emit_code;

    assign mapped  = scan_to_key(rx_byte, (state == ST_EXT) || (state == ST_EXT_BRK));
    // Keys whose code does not fit in CODE_W bits are dropped like unmapped ones.
    assign code_ok = (mapped != KEY_NONE) && (32'(mapped) < NUM_KEYS);
    assign is_ignored = (rx_byte == SC_E1) || (rx_byte == SC_AA) || (rx_byte == SC_FA) ||
                        (rx_byte == SC_EE) || (rx_byte == SC_FE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            emit_vld  <= 1'b0;
            emit_brk  <= 1'b0;
            emit_code <= '0;
        end else begin
            emit_vld <= 1'b0;
            if (frame_err) begin
                state <= ST_IDLE;
            end else if (byte_valid) begin
                case (state)
                    ST_IDLE: begin
                        if (rx_byte == SC_E0) begin
                            state <= ST_EXT;
                        end else if (rx_byte == SC_F0) begin
                            state <= ST_BRK;
                        end else if (!is_ignored) begin
                            emit_vld  <= code_ok;
                            emit_brk  <= 1'b0;
                            emit_code <= CODE_W'(mapped);
                        end
                    end
                    ST_BRK: begin
                        emit_vld  <= code_ok;
                        emit_brk  <= 1'b1;
                        emit_code <= CODE_W'(mapped);
                        state     <= ST_IDLE;
                    end
                    ST_EXT: begin
                        if (rx_byte == SC_F0) begin
                            state <= ST_EXT_BRK;
                        end else begin
                            emit_vld  <= code_ok;
                            emit_brk  <= 1'b0;
                            emit_code <= CODE_W'(mapped);
                            state     <= ST_IDLE;
                        end
                    end
                    ST_EXT_BRK: begin
                        emit_vld  <= code_ok;
                        emit_brk  <= 1'b1;
                        emit_code <= CODE_W'(mapped);
                        state     <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // ---------------------------------------------------------------
    // Key bitmap and event FIFO
    // ---------------------------------------------------------------
    logic [CODE_W-1:0] mem_code [FIFO_DEPTH];
    evt_flags_t        mem_flg  [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full, do_pop, do_push;
    evt_flags_t        new_flg;

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign do_pop  = evt_valid && evt_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = emit_vld && (!full || do_pop);

    // Repeat is judged against the bitmap before this event updates it.
    assign new_flg.brk = emit_brk;
    assign new_flg.rpt = !emit_brk && key_down[emit_code];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            key_down <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= emit_vld && full && !do_pop;
            if (emit_vld) begin
                key_down[emit_code] <= !emit_brk;
            end
            if (do_push) begin
                mem_code[wr_ptr] <= emit_code;
                mem_flg[wr_ptr]  <= new_flg;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head fields are forced to zero when empty so stale entries never show.
    assign evt_valid   = (count != '0);
    assign evt_code    = evt_valid ? mem_code[rd_ptr]    : '0;
    assign evt_release = evt_valid ? mem_flg[rd_ptr].brk : 1'b0;
    assign evt_repeat  = evt_valid ? mem_flg[rd_ptr].rpt : 1'b0;

endmodule

// File: tb/tb_ps2_key_decoder.sv
module tb_ps2_key_decoder;

    localparam int unsigned CODE_W = 5;
    localparam int unsigned FLEN   = 8;
    localparam int unsigned TMO    = 2000;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned HALF   = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic PS2Clk = 1'b1;
    logic PS2Data = 1'b1;
    logic evt_ready;
    logic evt_valid, evt_release, evt_repeat, frame_err, overflow;
    logic [CODE_W-1:0]    evt_code;
    logic [2**CODE_W-1:0] key_down;

    ps2_key_decoder #(
        .CODE_W(CODE_W),
        .FILTER_LEN(FLEN),
        .TIMEOUT_CYCLES(TMO),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .PS2Clk(PS2Clk),
        .PS2Data(PS2Data),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_code(evt_code),
        .evt_release(evt_release),
        .evt_repeat(evt_repeat),
        .key_down(key_down),
        .frame_err(frame_err),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] map_sc [29] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43,
                                8'h44, 8'h4D, 8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33,
                                8'h3B, 8'h42, 8'h4B, 8'h1A, 8'h22, 8'h21, 8'h2A, 8'h32,
                                8'h31, 8'h3A, 8'h5A, 8'h76, 8'h66};
    logic [4:0]  lut [2][256];
    bit          m_ext, m_brk;
    logic [31:0] held;
    logic [6:0]  exp_q [$];
    logic [6:0]  got_q [$];
    int          exp_err = 0;

    task automatic model_reset();
        m_ext = 0; m_brk = 0; held = '0;
    endtask

    task automatic model_err();
        m_ext = 0; m_brk = 0; exp_err++;
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [4:0] code;
        bit rel, rpt;
        if (b == 8'hF0 && !m_brk) begin
            m_brk = 1;
        end else if (b == 8'hE0 && !m_ext && !m_brk) begin
            m_ext = 1;
        end else if (!m_ext && !m_brk &&
                     (b == 8'hE1 || b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE)) begin
            // ignored
        end else begin
            code = lut[m_ext ? 1 : 0][b];
            rel  = m_brk;
            m_ext = 0; m_brk = 0;
            if (code != 0) begin
                rpt = !rel && held[code];
                held[code] = !rel;
                exp_q.push_back({code, rel, rpt});
            end
        end
    endtask

    // ---------------- monitor ----------------
    int   cyc = 0, bv_cyc = 0, rise_delay = -1;
    int   err_cnt = 0, ovf_cnt = 0;
    logic prev_v = 1'b0, hold = 1'b0;
    logic [6:0] h_ent;

    always @(negedge clk) begin
        cyc++;
        if (dut.u_rx.byte_valid) bv_cyc = cyc;
        if (evt_valid && !prev_v) rise_delay = cyc - bv_cyc;
        prev_v = evt_valid;
        if (frame_err) err_cnt++;
        if (overflow) ovf_cnt++;
        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            if (hold) chk("hold_stable", {evt_valid, evt_code, evt_release, evt_repeat}, {1'b1, h_ent});
            hold  = evt_valid && !evt_ready;
            h_ent = {evt_code, evt_release, evt_repeat};
            if (evt_valid && evt_ready) got_q.push_back({evt_code, evt_release, evt_repeat});
        end
    end

    // evt_ready driver: 0 = low, 1 = high, 2 = random per cycle
    int rdy_mode = 1;
    initial begin
        evt_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            evt_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [10:0] mk(input logic [7:0] b, input bit bad);
        return {1'b1, (~^b) ^ bad, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] fr, input int n);
        for (int i = 0; i < n; i++) begin
            PS2Data = fr[i];
            repeat (HALF) @(posedge clk);
            PS2Clk = 1'b0;
            repeat (HALF) @(posedge clk);
            PS2Clk = 1'b1;
        end
        PS2Data = 1'b1;
        repeat (HALF) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad);
        send_bits(mk(b, bad), 11);
        if (bad) model_err();
        else model_byte(b);
        repeat (30) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        chk("rst_outputs", {evt_valid, evt_code, evt_release, evt_repeat, frame_err, overflow}, '0);
        chk("rst_key_down", key_down, '0);
        got_q.delete();
        exp_q.delete();
    endtask

    typedef struct {
        logic [7:0] sc;
        bit         bad;
        int         nevt;
        logic [6:0] ent;
        int         err;
    } vec_t;
    vec_t tbl [$];

    task automatic add(input logic [7:0] sc, input bit bad, input int nevt,
                       input logic [4:0] code, input bit rel, input bit rpt, input int err);
        vec_t v;
        v.sc = sc; v.bad = bad; v.nevt = nevt; v.ent = {code, rel, rpt}; v.err = err;
        tbl.push_back(v);
    endtask

    logic [7:0] rb;
    bit         rbad;
    int         e0, o0, n;

    initial begin
        for (int e = 0; e < 2; e++)
            for (int s = 0; s < 256; s++) lut[e][s] = '0;
        for (int k = 0; k < 29; k++) lut[0][map_sc[k]] = 5'(k + 1);
        lut[1][8'h6B] = 5'd30;
        lut[1][8'h74] = 5'd31;
        model_reset();

        //   sc     bad nevt code rel rpt err
        add(8'h1C, 0, 1, 11, 0, 0, 0);
        add(8'h1C, 0, 1, 11, 0, 1, 0);
        add(8'hF0, 0, 0,  0, 0, 0, 0);
        add(8'h1C, 0, 1, 11, 1, 0, 0);
        add(8'hE0, 0, 0,  0, 0, 0, 0);
        add(8'h6B, 0, 1, 30, 0, 0, 0);
        add(8'hE0, 0, 0,  0, 0, 0, 0);
        add(8'hF0, 0, 0,  0, 0, 0, 0);
        add(8'h74, 0, 1, 31, 1, 0, 0);
        add(8'h6B, 0, 0,  0, 0, 0, 0);
        add(8'h15, 1, 0,  0, 0, 0, 1);
        add(8'hAA, 0, 0,  0, 0, 0, 0);
        add(8'h1D, 0, 1,  2, 0, 0, 0);
        add(8'hF0, 0, 0,  0, 0, 0, 0);
        add(8'h1D, 0, 1,  2, 1, 0, 0);
        add(8'hE1, 0, 0,  0, 0, 0, 0);

        rdy_mode = 1;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("init_outputs", {evt_valid, evt_code, evt_release, evt_repeat, frame_err, overflow}, '0);
        chk("init_key_down", key_down, '0);

        // ---- table-driven single frames ----
        foreach (tbl[i]) begin
            got_q.delete();
            e0 = err_cnt;
            send_frame(tbl[i].sc, tbl[i].bad);
            chk($sformatf("v%0d_nevt", i), got_q.size(), tbl[i].nevt);
            if (tbl[i].nevt > 0 && got_q.size() > 0)
                chk($sformatf("v%0d_event", i), got_q[0], tbl[i].ent);
            chk($sformatf("v%0d_frame_err", i), err_cnt - e0, tbl[i].err);
            chk($sformatf("v%0d_key_down", i), key_down, held);
            if (i == 0) chk("valid_latency", rise_delay, 2);
        end
        exp_q.delete();

        // ---- timeout mid-frame ----
        got_q.delete();
        e0 = err_cnt;
        send_bits(mk(8'h15, 0), 6);
        repeat (TMO + 100) @(posedge clk);
        model_err();
        chk("timeout_err", err_cnt - e0, 1);
        send_frame(8'h1D, 0);
        chk("after_tmo_nevt", got_q.size(), 1);
        if (got_q.size() > 0) chk("after_tmo_event", got_q[0], {5'd2, 1'b0, 1'b0});
        exp_q.delete();

        // ---- overflow with consumer stalled ----
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        got_q.delete();
        o0 = ovf_cnt;
        send_frame(8'h15, 0);
        send_frame(8'h1D, 0);
        send_frame(8'h24, 0);
        send_frame(8'h2D, 0);
        send_frame(8'h2C, 0);
        chk("ovf_pulses", ovf_cnt - o0, 1);
        chk("ovf_no_pop", got_q.size(), 0);
        chk("ovf_head", {evt_valid, evt_code, evt_release, evt_repeat}, {1'b1, 5'd1, 1'b0, 1'b0});
        chk("ovf_key_down", key_down, held);
        rdy_mode = 1;
        repeat (20) @(posedge clk);
        chk("ovf_drain_n", got_q.size(), 4);
        if (got_q.size() == 4) begin
            chk("ovf_pop0", got_q[0], {5'd1, 1'b0, 1'b0});
            chk("ovf_pop1", got_q[1], {5'd2, 1'b0, 1'b1});
            chk("ovf_pop2", got_q[2], {5'd3, 1'b0, 1'b0});
            chk("ovf_pop3", got_q[3], {5'd4, 1'b0, 1'b0});
        end
        chk("ovf_empty", evt_valid, 1'b0);
        exp_q.delete();

        // ---- reset mid-frame (with an event pending) and after F0 ----
        rdy_mode = 0;
        send_frame(8'h1C, 0);
        send_bits(mk(8'h33, 0), 5);
        do_reset();
        rdy_mode = 1;
        send_frame(8'h24, 0);
        chk("rst1_nevt", got_q.size(), 1);
        if (got_q.size() > 0) chk("rst1_event", got_q[0], {5'd3, 1'b0, 1'b0});
        send_frame(8'hF0, 0);
        do_reset();
        send_frame(8'h24, 0);
        chk("rst2_nevt", got_q.size(), 1);
        if (got_q.size() > 0) chk("rst2_event", got_q[0], {5'd3, 1'b0, 1'b0});
        chk("rst2_key_down", key_down, held);

        // ---- randomized frames against the model ----
        got_q.delete();
        exp_q.delete();
        exp_err = 0;
        e0 = err_cnt;
        rdy_mode = 2;
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 11))
                0:       rb = 8'hF0;
                1:       rb = 8'hE0;
                2:       rb = 8'($urandom_range(0, 255));
                3:       rb = 8'h6B;
                4:       rb = 8'h74;
                default: rb = map_sc[$urandom_range(0, 28)];
            endcase
            rbad = ($urandom_range(0, 9) == 0);
            send_frame(rb, rbad);
            for (int w = 0; w < 300 && got_q.size() < exp_q.size(); w++) @(posedge clk);
            chk($sformatf("rnd%0d_nevt", t), got_q.size(), exp_q.size());
            while (got_q.size() > 0 && exp_q.size() > 0) begin
                chk($sformatf("rnd%0d_event", t), got_q.pop_front(), exp_q.pop_front());
            end
            got_q.delete();
            exp_q.delete();
            chk($sformatf("rnd%0d_key_down", t), key_down, held);
        end
        chk("rnd_frame_errs", err_cnt - e0, exp_err);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
